// File: rtl/ysyx_23060075_wbu_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060075_wbu_if
//
// This interface bundles every non-clock, non-reset signal of the writeback
// unit. It has four signal groups:
//   upstream result  : in_valid, in_ready, in_pc, in_rd, in_rd_wen,
//                      in_is_load, in_funct3, in_addr_low,
//                      in_alu_result, in_mem_rdata
//   GPR write port   : gpr_w, gpr_w_addr, gpr_w_en
//   commit handshake : commit_valid, commit_ready, commit_pc, load_err
//   hazard query     : hz_rs1_addr, hz_rs2_addr, hz_stall
//
// Modports:
//   slave  - the writeback unit itself
//   master - the surrounding core (or a testbench) driving the WBU
// ----------------------------------------------------------------------------
interface ysyx_23060075_wbu_if #(
  parameter int ISA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // upstream result
  logic                      in_valid;
  logic                      in_ready;
  logic [ISA_WIDTH-1:0]      in_pc;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic                      in_rd_wen;
  logic                      in_is_load;
  logic [2:0]                in_funct3;
  logic [1:0]                in_addr_low;
  logic [ISA_WIDTH-1:0]      in_alu_result;
  logic [ISA_WIDTH-1:0]      in_mem_rdata;

  // GPR write port
  logic [ISA_WIDTH-1:0]      gpr_w;
  logic [REG_ADDR_WIDTH-1:0] gpr_w_addr;
  logic                      gpr_w_en;

  // commit handshake toward fetch
  logic                      commit_valid;
  logic                      commit_ready;
  logic [ISA_WIDTH-1:0]      commit_pc;
  logic                      load_err;

  // hazard query from decode
  logic [REG_ADDR_WIDTH-1:0] hz_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] hz_rs2_addr;
  logic                      hz_stall;

  modport slave (
    input  in_valid, in_pc, in_rd, in_rd_wen, in_is_load, in_funct3,
           in_addr_low, in_alu_result, in_mem_rdata,
           commit_ready, hz_rs1_addr, hz_rs2_addr,
    output in_ready, gpr_w, gpr_w_addr, gpr_w_en,
           commit_valid, commit_pc, load_err, hz_stall
  );

  modport master (
    output in_valid, in_pc, in_rd, in_rd_wen, in_is_load, in_funct3,
           in_addr_low, in_alu_result, in_mem_rdata,
           commit_ready, hz_rs1_addr, hz_rs2_addr,
    input  in_ready, gpr_w, gpr_w_addr, gpr_w_en,
           commit_valid, commit_pc, load_err, hz_stall
  );
endinterface

// File: rtl/ysyx_23060075_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_23060075_wbu
//
// Writeback unit of the multi-cycle core. It holds one retired instruction
// in a single-entry buffer (EMPTY/FULL). Load data is lane-selected and
// sign/zero extended when the entry is accepted, so the buffer always
// holds final write data. While FULL the unit drives the GPR write port
// and offers a commit to fetch. It also reports RAW hazards against the
// buffered destination register.
//
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - ysyx_23060075_wbu_if.slave. It carries the upstream result
//          handshake, the GPR write port, the commit handshake and the
//          hazard query.
//
// Load extension is defined for ISA_WIDTH = 32 only.
// ----------------------------------------------------------------------------
module ysyx_23060075_wbu #(
  parameter int ISA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic                clk,
  input logic                rst,
  ysyx_23060075_wbu_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // --------------------------------------------------------------------------
  // Buffer state
  // --------------------------------------------------------------------------
  logic [0:0]                state_q,    state_d;
  logic [ISA_WIDTH-1:0]      pc_q,       pc_d;
  logic [ISA_WIDTH-1:0]      wdata_q,    wdata_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,       rd_d;
  logic                      rd_wen_q,   rd_wen_d;
  logic                      load_err_q, load_err_d;

  logic full;
  logic accept;
  logic commit;
  logic rd_live;

  // --------------------------------------------------------------------------
  // Load data selection and extension
  // --------------------------------------------------------------------------
  logic [7:0]           byte_lane [4];
  logic [7:0]           sel_byte;
  logic [15:0]          sel_half;
  logic [ISA_WIDTH-1:0] load_data;
  logic                 load_bad;
  logic [ISA_WIDTH-1:0] in_wdata;
  logic                 in_err;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = bus.in_mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sel_byte  = byte_lane[bus.in_addr_low];
    // Halfword loads are assumed aligned, so addr_low[0] plays no part.
    sel_half  = bus.in_addr_low[1] ? bus.in_mem_rdata[31:16]
                                   : bus.in_mem_rdata[15:0];
    load_data = '0;
    load_bad  = 1'b0;
    case (bus.in_funct3)
      3'b000:  load_data = {{(ISA_WIDTH-8){sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{(ISA_WIDTH-16){sel_half[15]}}, sel_half};
      3'b010:  load_data = bus.in_mem_rdata;
      3'b100:  load_data = {{(ISA_WIDTH-8){1'b0}}, sel_byte};
      3'b101:  load_data = {{(ISA_WIDTH-16){1'b0}}, sel_half};
      // An unsupported width writes zero and raises load_err. The entry
      // still commits, so the core decides how to trap.
      default: load_bad  = 1'b1;
    endcase

    in_wdata = bus.in_is_load ? load_data : bus.in_alu_result;
    in_err   = bus.in_is_load & load_bad;
  end

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  assign full         = (state_q == ST_FULL);
  // Committing the current entry frees the slot in the same cycle. This
  // allows one instruction per cycle when commit_ready is held high.
  assign bus.in_ready = ~full | bus.commit_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign commit       = full & bus.commit_ready;
  assign rd_live      = rd_wen_q & (rd_q != '0);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rd_wen_d   = rd_wen_q;
    load_err_d = load_err_q;

    if (accept) begin
      // Covers both EMPTY->FULL and a FULL commit with a refill.
      state_d    = ST_FULL;
      pc_d       = bus.in_pc;
      wdata_d    = in_wdata;
      rd_d       = bus.in_rd;
      rd_wen_d   = bus.in_rd_wen;
      load_err_d = in_err;
    end else if (commit) begin
      // Draining clears the fields. Registered outputs then read zero
      // whenever the buffer is empty, the same as after reset.
      state_d    = ST_EMPTY;
      pc_d       = '0;
      wdata_d    = '0;
      rd_d       = '0;
      rd_wen_d   = 1'b0;
      load_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      pc_q       <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rd_wen_q   <= rd_wen_d;
      load_err_q <= load_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.commit_valid = full;
  assign bus.commit_pc    = pc_q;
  assign bus.load_err     = load_err_q;
  assign bus.gpr_w        = full ? wdata_q : '0;
  assign bus.gpr_w_addr   = full ? rd_q : '0;
  // x0 writes are dropped here as well as in the register file. This
  // keeps the write-enable trace clean for anything observing the port.
  assign bus.gpr_w_en     = commit & rd_live;
  assign bus.hz_stall     = full & rd_live &
                            ((bus.hz_rs1_addr == rd_q) |
                             (bus.hz_rs2_addr == rd_q));

endmodule

// File: tb/tb_ysyx_23060075_wbu.sv
module tb_ysyx_23060075_wbu;
  localparam int W = 32;
  localparam int A = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060075_wbu_if #(.ISA_WIDTH(W), .REG_ADDR_WIDTH(A)) bus ();

  ysyx_23060075_wbu #(.ISA_WIDTH(W), .REG_ADDR_WIDTH(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  // Independent reference for writeback data: shift the word down, then extend.
  function automatic logic [31:0] ref_wdata(input logic ld, input logic [2:0] f3,
                                            input logic [1:0] al, input logic [31:0] mem,
                                            input logic [31:0] alu, output logic err);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    err = 1'b0;
    if (!ld) return alu;
    sh_b = mem >> (8 * al);
    sh_h = al[1] ? (mem >> 16) : mem;
    case (f3)
      3'b000: return {{24{sh_b[7]}}, sh_b[7:0]};
      3'b100: return {24'h0, sh_b[7:0]};
      3'b001: return {{16{sh_h[15]}}, sh_h[15:0]};
      3'b101: return {16'h0, sh_h[15:0]};
      3'b010: return mem;
      default: begin
        err = 1'b1;
        return 32'h0;
      end
    endcase
  endfunction

  task automatic drive_idle();
    bus.in_valid      = 1'b0;
    bus.in_pc         = '0;
    bus.in_rd         = '0;
    bus.in_rd_wen     = 1'b0;
    bus.in_is_load    = 1'b0;
    bus.in_funct3     = '0;
    bus.in_addr_low   = '0;
    bus.in_alu_result = '0;
    bus.in_mem_rdata  = '0;
  endtask

  task automatic drive_in(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                          input logic ld, input logic [2:0] f3, input logic [1:0] al,
                          input logic [31:0] alu, input logic [31:0] mem);
    bus.in_valid      = 1'b1;
    bus.in_pc         = pc;
    bus.in_rd         = rd;
    bus.in_rd_wen     = wen;
    bus.in_is_load    = ld;
    bus.in_funct3     = f3;
    bus.in_addr_low   = al;
    bus.in_alu_result = alu;
    bus.in_mem_rdata  = mem;
  endtask

  // Push the currently driven transaction as an expectation (model-computed).
  task automatic push_model();
    exp_t e;
    logic err;
    e.pc   = bus.in_pc;
    e.rd   = bus.in_rd;
    e.data = ref_wdata(bus.in_is_load, bus.in_funct3, bus.in_addr_low,
                       bus.in_mem_rdata, bus.in_alu_result, err);
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.commit_ready = 1'b0;
    bus.hz_rs1_addr  = '0;
    bus.hz_rs2_addr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.in_ready, bus.commit_valid, bus.gpr_w_en, bus.load_err, bus.hz_stall} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy/cv/en/err/hz=%b, want 10000",
               {bus.in_ready, bus.commit_valid, bus.gpr_w_en, bus.load_err, bus.hz_stall});
    end
    total++;
    if ({bus.gpr_w, bus.gpr_w_addr, bus.commit_pc} !== '0) begin
      bad++;
      $display("FAIL reset_data: got w=%h addr=%0d pc=%h, want all 0",
               bus.gpr_w, bus.gpr_w_addr, bus.commit_pc);
    end
    rst = 1'b0;
    next_cycle();

    // Fill the buffer, hold it, then reset mid-entry.
    drive_in(32'h8000_0040, 5'd3, 1'b1, 1'b0, 3'b000, 2'd0, 32'h55, 32'h0);
    bus.hz_rs1_addr = 5'd3;
    next_cycle();
    drive_idle();
    @(negedge clk);
    total++;
    if ({bus.commit_valid, bus.hz_stall, bus.gpr_w} !== {1'b1, 1'b1, 32'h55}) begin
      bad++;
      $display("FAIL reset_prefill: got cv=%b hz=%b w=%h, want cv=1 hz=1 w=00000055",
               bus.commit_valid, bus.hz_stall, bus.gpr_w);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, bus.commit_valid, bus.gpr_w_en, bus.load_err, bus.hz_stall} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_async_ctrl: got rdy/cv/en/err/hz=%b, want 10000",
               {bus.in_ready, bus.commit_valid, bus.gpr_w_en, bus.load_err, bus.hz_stall});
    end
    total++;
    if ({bus.gpr_w, bus.gpr_w_addr, bus.commit_pc} !== '0) begin
      bad++;
      $display("FAIL reset_async_data: got w=%h addr=%0d pc=%h, want all 0",
               bus.gpr_w, bus.gpr_w_addr, bus.commit_pc);
    end
    bus.commit_ready = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.commit_valid, bus.gpr_w_en} !== 2'b00) begin
      bad++;
      $display("FAIL reset_discard: got cv=%b en=%b, want cv=0 en=0",
               bus.commit_valid, bus.gpr_w_en);
    end
    bus.hz_rs1_addr = '0;
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_alu_write();
    exp_t e;
    bus.commit_ready = 1'b1;
    drive_in(32'h8000_0000, 5'd5, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_1234, 32'hDEAD_BEEF);
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL alu_ready: got in_ready=%b, want 1", bus.in_ready);
    end
    sb.push_back('{pc: 32'h8000_0000, rd: 5'd5, data: 32'h0000_1234, err: 1'b0});
    next_cycle();
    drive_idle();
    @(negedge clk);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL alu_commit: got commit with empty scoreboard, want queued entry");
    end else begin
      e = sb.pop_front();
      if ({bus.commit_valid, bus.gpr_w_en, bus.gpr_w_addr, bus.gpr_w, bus.commit_pc, bus.load_err}
          !== {1'b1, 1'b1, e.rd, e.data, e.pc, e.err}) begin
        bad++;
        $display("FAIL alu_commit: got cv=%b en=%b addr=%0d w=%h pc=%h err=%b, want cv=1 en=1 addr=%0d w=%h pc=%h err=%b",
                 bus.commit_valid, bus.gpr_w_en, bus.gpr_w_addr, bus.gpr_w, bus.commit_pc, bus.load_err,
                 e.rd, e.data, e.pc, e.err);
      end
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({bus.commit_valid, bus.gpr_w_en, bus.in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL alu_drain: got cv=%b en=%b rdy=%b, want cv=0 en=0 rdy=1",
               bus.commit_valid, bus.gpr_w_en, bus.in_ready);
    end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_loads();
    logic        ld_t  [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [2:0]  f3_t  [11] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011,
                                3'b000, 3'b101, 3'b110, 3'b111, 3'b011};
    logic [1:0]  al_t  [11] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [31:0] exp_t_d [11] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_7F81,
                                  32'h80F0_7F81, 32'h0000_0000, 32'h0000_007F, 32'h0000_80F0,
                                  32'h0000_0000, 32'h0000_0000, 32'h0BAD_F00D};
    logic        err_t [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
    exp_t e;
    bus.commit_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive_in(32'h8000_1000 + 32'(4 * i), 5'(i + 1), 1'b1, ld_t[i], f3_t[i], al_t[i],
               32'h0BAD_F00D, 32'h80F0_7F81);
      @(negedge clk);
      if (bus.in_ready === 1'b1)
        sb.push_back('{pc: 32'h8000_1000 + 32'(4 * i), rd: 5'(i + 1), data: exp_t_d[i], err: err_t[i]});
      next_cycle();
      drive_idle();
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL load_%0d: got no queued entry, want one committed entry", i);
      end else begin
        e = sb.pop_front();
        if ({bus.commit_valid, bus.gpr_w_en, bus.gpr_w_addr, bus.gpr_w, bus.commit_pc, bus.load_err}
            !== {1'b1, 1'b1, e.rd, e.data, e.pc, e.err}) begin
          bad++;
          $display("FAIL load_%0d f3=%b al=%0d: got cv=%b en=%b addr=%0d w=%h pc=%h err=%b, want cv=1 en=1 addr=%0d w=%h pc=%h err=%b",
                   i, f3_t[i], al_t[i], bus.commit_valid, bus.gpr_w_en, bus.gpr_w_addr, bus.gpr_w,
                   bus.commit_pc, bus.load_err, e.rd, e.data, e.pc, e.err);
        end
      end
      next_cycle();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    exp_t e;
    bus.commit_ready = 1'b0;
    drive_in(32'h0000_0100, 5'd9, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_AAAA, 32'h0);
    @(negedge clk);
    if (bus.in_ready === 1'b1) push_model();
    next_cycle();
    // Offer B immediately; it must be refused while commit_ready is low.
    drive_in(32'h0000_0104, 5'd10, 1'b1, 1'b1, 3'b001, 2'd2, 32'h0, 32'h1234_8765);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0 ||
          {bus.in_ready, bus.gpr_w_en, bus.commit_valid, bus.gpr_w, bus.gpr_w_addr, bus.commit_pc}
          !== {1'b0, 1'b0, 1'b1, sb[0].data, sb[0].rd, sb[0].pc}) begin
        bad++;
        $display("FAIL bp_hold_%0d: got rdy=%b en=%b cv=%b w=%h addr=%0d pc=%h, want rdy=0 en=0 cv=1 w=0000aaaa addr=9 pc=00000100",
                 c, bus.in_ready, bus.gpr_w_en, bus.commit_valid, bus.gpr_w, bus.gpr_w_addr, bus.commit_pc);
      end
      next_cycle();
    end
    bus.commit_ready = 1'b1;
    @(negedge clk);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL bp_release: got no queued entry, want entry A");
    end else begin
      e = sb.pop_front();
      if ({bus.in_ready, bus.gpr_w_en, bus.gpr_w, bus.gpr_w_addr, bus.commit_pc}
          !== {1'b1, 1'b1, e.data, e.rd, e.pc}) begin
        bad++;
        $display("FAIL bp_release: got rdy=%b en=%b w=%h addr=%0d pc=%h, want rdy=1 en=1 w=%h addr=%0d pc=%h",
                 bus.in_ready, bus.gpr_w_en, bus.gpr_w, bus.gpr_w_addr, bus.commit_pc, e.data, e.rd, e.pc);
      end
    end
    if (bus.in_ready === 1'b1) push_model();
    next_cycle();
    drive_idle();
    @(negedge clk);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL bp_next: got no queued entry, want entry B");
    end else begin
      e = sb.pop_front();
      if ({bus.commit_valid, bus.gpr_w_en, bus.gpr_w, bus.gpr_w_addr, bus.commit_pc}
          !== {1'b1, 1'b1, e.data, e.rd, e.pc}) begin
        bad++;
        $display("FAIL bp_next: got cv=%b en=%b w=%h addr=%0d pc=%h, want cv=1 en=1 w=%h addr=%0d pc=%h",
                 bus.commit_valid, bus.gpr_w_en, bus.gpr_w, bus.gpr_w_addr, bus.commit_pc, e.data, e.rd, e.pc);
      end
    end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_x0_hazard();
    bus.commit_ready = 1'b1;
    bus.hz_rs1_addr  = 5'd0;
    bus.hz_rs2_addr  = 5'd0;
    drive_in(32'h0000_0200, 5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_DEAD, 32'h0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    total++;
    if ({bus.commit_valid, bus.gpr_w_en, bus.hz_stall} !== 3'b100) begin
      bad++;
      $display("FAIL x0_write: got cv=%b en=%b hz=%b, want cv=1 en=0 hz=0",
               bus.commit_valid, bus.gpr_w_en, bus.hz_stall);
    end
    next_cycle();

    bus.commit_ready = 1'b0;
    drive_in(32'h0000_0204, 5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_0007, 32'h0);
    next_cycle();
    drive_idle();
    bus.hz_rs1_addr = 5'd3;
    bus.hz_rs2_addr = 5'd7;
    @(negedge clk);
    total++;
    if (bus.hz_stall !== 1'b1) begin
      bad++;
      $display("FAIL hz_rs2_match: got hz_stall=%b, want 1", bus.hz_stall);
    end
    bus.hz_rs1_addr = 5'd6;
    bus.hz_rs2_addr = 5'd6;
    #1;
    total++;
    if (bus.hz_stall !== 1'b0) begin
      bad++;
      $display("FAIL hz_nomatch: got hz_stall=%b, want 0", bus.hz_stall);
    end
    bus.hz_rs1_addr = 5'd7;
    #1;
    total++;
    if (bus.hz_stall !== 1'b1) begin
      bad++;
      $display("FAIL hz_rs1_match: got hz_stall=%b, want 1", bus.hz_stall);
    end
    bus.commit_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if ({bus.commit_valid, bus.hz_stall} !== 2'b00) begin
      bad++;
      $display("FAIL hz_after_drain: got cv=%b hz=%b, want cv=0 hz=0", bus.commit_valid, bus.hz_stall);
    end
    bus.hz_rs1_addr = 5'd0;
    bus.hz_rs2_addr = 5'd0;
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [2:0] f3_ok [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    exp_t e;
    bus.commit_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8)
        drive_in(32'h8000_2000 + 32'(4 * i), 5'($urandom_range(1, 31)), 1'b1,
                 1'($urandom_range(0, 1)), f3_ok[$urandom_range(0, 4)],
                 2'($urandom_range(0, 3)), $urandom, $urandom);
      else
        drive_idle();
      @(negedge clk);
      if (i < 8) begin
        total++;
        if (bus.in_ready !== 1'b1) begin
          bad++;
          $display("FAIL stream_ready_%0d: got in_ready=%b, want 1", i, bus.in_ready);
        end
      end
      if (i > 0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL stream_commit_%0d: got no queued entry, want one", i - 1);
        end else begin
          e = sb.pop_front();
          if ({bus.commit_valid, bus.gpr_w_en, bus.gpr_w_addr, bus.gpr_w, bus.commit_pc, bus.load_err}
              !== {1'b1, 1'b1, e.rd, e.data, e.pc, e.err}) begin
            bad++;
            $display("FAIL stream_commit_%0d: got cv=%b en=%b addr=%0d w=%h pc=%h err=%b, want cv=1 en=1 addr=%0d w=%h pc=%h err=%b",
                     i - 1, bus.commit_valid, bus.gpr_w_en, bus.gpr_w_addr, bus.gpr_w, bus.commit_pc,
                     bus.load_err, e.rd, e.data, e.pc, e.err);
          end
        end
      end
      if (i < 8 && bus.in_ready === 1'b1) push_model();
      next_cycle();
    end
    @(negedge clk);
    total++;
    if ({bus.commit_valid, sb.size() == 0} !== 2'b01) begin
      bad++;
      $display("FAIL stream_drain: got cv=%b leftover=%0d, want cv=0 leftover=0",
               bus.commit_valid, sb.size());
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_loads();
    test_backpressure();
    test_x0_hazard();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, want completion");
    $fatal(1, "timeout");
  end

endmodule
